sudoku_ram_arbiter: RTL and testbench

Time-multiplexes one single-port sudokuRAM instance (4 rows × 24 bits) between the interface controller (read/write) and the game checker (read-only). It sits between those two blocks and the RAM, replacing the dual-port arrangement. It issues at most one RAM access per cycle and routes registered read data back to the requester that owns it. It also bounds controller bursts so the checker can never be starved.

---
 rtl/sudoku_pkg.sv | 21 ++
 rtl/sudoku_ram_arbiter_if.sv | 40 ++++
 rtl/sudoku_arb_select.sv | 57 +++++
 rtl/sudoku_ram_arbiter.sv | 98 +++++++++
 tb/tb_sudoku_ram_arbiter.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sudoku_pkg.sv
// Shared sudoku types and sizes: RAM geometry, requester owner tags and the
// arbiter state encoding. Also used by the game checker and interface controller.
package sudoku_pkg;

    localparam int ADDR_W = 2;
    localparam int DATA_W = 24;
    localparam int ROWS   = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CTRL = 2'd1,
        OWN_CHK  = 2'd2
    } owner_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CTRL = 2'd1,
        ST_CHK  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/sudoku_ram_arbiter_if.sv
// Bundle of the controller, checker and RAM-side signals around the arbiter.
// Slave modport is the arbiter; master modport is the requesters plus the RAM.
interface sudoku_ram_arbiter_if;
    import sudoku_pkg::*;

    // Handshake: req (with we/addr/wdata) is a level held stable until the
    // matching gnt pulse; req still high in the gnt cycle asks for another
    // access. rvalid pulses once per granted read, two cycles after sampling.
    logic              ctrl_req;
    logic              ctrl_we;
    logic [ADDR_W-1:0] ctrl_addr;
    logic [DATA_W-1:0] ctrl_wdata;
    logic              ctrl_gnt;
    logic              ctrl_rvalid;
    logic [DATA_W-1:0] ctrl_rdata;

    logic              chk_req;
    logic [ADDR_W-1:0] chk_addr;
    logic              chk_gnt;
    logic              chk_rvalid;
    logic [DATA_W-1:0] chk_rdata;

    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_wren;
    logic [DATA_W-1:0] ram_q;

    modport slave (
        input  ctrl_req, ctrl_we, ctrl_addr, ctrl_wdata, chk_req, chk_addr, ram_q,
        output ctrl_gnt, ctrl_rvalid, ctrl_rdata, chk_gnt, chk_rvalid, chk_rdata,
               ram_addr, ram_wdata, ram_wren
    );

    modport master (
        output ctrl_req, ctrl_we, ctrl_addr, ctrl_wdata, chk_req, chk_addr, ram_q,
        input  ctrl_gnt, ctrl_rvalid, ctrl_rdata, chk_gnt, chk_rvalid, chk_rdata,
               ram_addr, ram_wdata, ram_wren
    );

endinterface

// File: rtl/sudoku_arb_select.sv
// Next-owner decision for the sudoku RAM slot. With SUDOKU_ARB_FAIRNESS_EN
// defined, a saturating burst counter forces a checker slot after MAX_CTRL_BURST
// controller grants; otherwise the controller has strict priority.
module sudoku_arb_select
    import sudoku_pkg::*;
#(
    parameter int MAX_CTRL_BURST = 4
) (
`ifdef SUDOKU_ARB_FAIRNESS_EN
    input  logic   CLK,
    input  logic   RST,
`endif
    input  logic   enable,
    input  logic   ctrl_req,
    input  logic   chk_req,
    output owner_t sel
);

    if (MAX_CTRL_BURST < 1) begin : g_bad_burst
        $error("MAX_CTRL_BURST must be at least 1");
    end

`ifdef SUDOKU_ARB_FAIRNESS_EN
    localparam int CNT_W = $clog2(MAX_CTRL_BURST + 1);

    logic [CNT_W-1:0] burst_q;
    logic [CNT_W-1:0] burst_d;
    logic             limit_hit;

    always_comb begin
        limit_hit = (burst_q == CNT_W'(MAX_CTRL_BURST));
        sel       = OWN_NONE;
        if (enable) begin
            if (chk_req && (!ctrl_req || limit_hit)) sel = OWN_CHK;
            else if (ctrl_req)                       sel = OWN_CTRL;
        end
        // Only counts while the checker is actually waiting; saturates at the limit.
        burst_d = burst_q;
        if (!chk_req || sel == OWN_CHK)           burst_d = '0;
        else if (sel == OWN_CTRL && !limit_hit)   burst_d = burst_q + 1'b1;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) burst_q <= '0;
        else      burst_q <= burst_d;
    end
`else
    always_comb begin
        sel = OWN_NONE;
        if (enable) begin
            if (ctrl_req)     sel = OWN_CTRL;
            else if (chk_req) sel = OWN_CHK;
        end
    end
`endif

endmodule

// File: rtl/sudoku_ram_arbiter.sv
// Shares one single-port sudoku RAM between the interface controller and the
// game checker. Optional fairness build: define SUDOKU_ARB_FAIRNESS_EN.
module sudoku_ram_arbiter
    import sudoku_pkg::*;
#(
    parameter int MAX_CTRL_BURST = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    sudoku_ram_arbiter_if.slave  bus,
    output arb_state_t           dbg_state
);

    arb_state_t        state_q, state_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              ram_wren_q, ram_wren_d;
    logic              ctrl_rvalid_q, ctrl_rvalid_d;
    logic              chk_rvalid_q, chk_rvalid_d;
    logic [DATA_W-1:0] ctrl_hold_q, ctrl_hold_d;
    logic [DATA_W-1:0] chk_hold_q, chk_hold_d;
    logic              rst_done_q, rst_done_d;
    owner_t            sel;

    sudoku_arb_select #(.MAX_CTRL_BURST(MAX_CTRL_BURST)) u_select (
`ifdef SUDOKU_ARB_FAIRNESS_EN
        .CLK      (CLK),
        .RST      (RST),
`endif
        .enable   (rst_done_q),
        .ctrl_req (bus.ctrl_req),
        .chk_req  (bus.chk_req),
        .sel      (sel)
    );

    always_comb begin
        rst_done_d  = 1'b1;
        state_d     = ST_IDLE;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_wren_d  = 1'b0;
        case (sel)
            OWN_CTRL: begin
                state_d     = ST_CTRL;
                ram_addr_d  = bus.ctrl_addr;
                ram_wdata_d = bus.ctrl_wdata;
                ram_wren_d  = bus.ctrl_we;
            end
            OWN_CHK: begin
                state_d    = ST_CHK;
                ram_addr_d = bus.chk_addr;
            end
            default: ;
        endcase
        // The slot owner and read flag ride one stage behind the RAM access.
        ctrl_rvalid_d = (state_q == ST_CTRL) && !ram_wren_q;
        chk_rvalid_d  = (state_q == ST_CHK);
        ctrl_hold_d   = ctrl_rvalid_q ? bus.ram_q : ctrl_hold_q;
        chk_hold_d    = chk_rvalid_q  ? bus.ram_q : chk_hold_q;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q       <= ST_IDLE;
            ram_addr_q    <= '0;
            ram_wdata_q   <= '0;
            ram_wren_q    <= 1'b0;
            ctrl_rvalid_q <= 1'b0;
            chk_rvalid_q  <= 1'b0;
            ctrl_hold_q   <= '0;
            chk_hold_q    <= '0;
            rst_done_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            ram_addr_q    <= ram_addr_d;
            ram_wdata_q   <= ram_wdata_d;
            ram_wren_q    <= ram_wren_d;
            ctrl_rvalid_q <= ctrl_rvalid_d;
            chk_rvalid_q  <= chk_rvalid_d;
            ctrl_hold_q   <= ctrl_hold_d;
            chk_hold_q    <= chk_hold_d;
            rst_done_q    <= rst_done_d;
        end
    end

    assign bus.ctrl_gnt    = (state_q == ST_CTRL);
    assign bus.chk_gnt     = (state_q == ST_CHK);
    assign bus.ram_addr    = ram_addr_q;
    assign bus.ram_wdata   = ram_wdata_q;
    assign bus.ram_wren    = ram_wren_q;
    assign bus.ctrl_rvalid = ctrl_rvalid_q;
    assign bus.chk_rvalid  = chk_rvalid_q;
    // The RAM output is shown live to the owner; the other side keeps its last word.
    assign bus.ctrl_rdata  = ctrl_rvalid_q ? bus.ram_q : ctrl_hold_q;
    assign bus.chk_rdata   = chk_rvalid_q  ? bus.ram_q : chk_hold_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_sudoku_ram_arbiter.sv
// Self-checking bench for sudoku_ram_arbiter: directed vector table, burst
// sequences, reset corner cases and random traffic against a reference model.
module tb_sudoku_ram_arbiter;
    import sudoku_pkg::*;

    localparam int MAXB = 4;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    arb_state_t dbg_state;
    int         tests = 0;
    int         fails = 0;

    always #5 CLK = ~CLK;

    sudoku_ram_arbiter_if bus();

    sudoku_ram_arbiter #(.MAX_CTRL_BURST(MAXB)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Single-port RAM with one-cycle registered read
    logic [DATA_W-1:0] ram_mem [ROWS] = '{24'h111111, 24'h222222, 24'h333333, 24'h444444};
    always @(posedge CLK) begin
        if (bus.ram_wren) ram_mem[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_q <= ram_mem[bus.ram_addr];
    end

    typedef struct {
        logic              cr;
        logic              cw;
        logic [ADDR_W-1:0] ca;
        logic [DATA_W-1:0] cd;
        logic              kr;
        logic [ADDR_W-1:0] ka;
        logic              e_cg;
        logic              e_kg;
        logic              e_crv;
        logic              e_krv;
        logic [DATA_W-1:0] e_crd;
        logic [DATA_W-1:0] e_krd;
        logic              e_wren;
        logic [ADDR_W-1:0] e_addr;
    } vec_t;

    function automatic vec_t mk(input logic cr, cw, input logic [1:0] ca, input logic [23:0] cd,
                                input logic kr, input logic [1:0] ka,
                                input logic e_cg, e_kg, e_crv, e_krv,
                                input logic [23:0] e_crd, e_krd,
                                input logic e_wren, input logic [1:0] e_addr);
        vec_t v;
        v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd; v.kr = kr; v.ka = ka;
        v.e_cg = e_cg; v.e_kg = e_kg; v.e_crv = e_crv; v.e_krv = e_krv;
        v.e_crd = e_crd; v.e_krd = e_krd; v.e_wren = e_wren; v.e_addr = e_addr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic cr, cw, input logic [1:0] ca, input logic [23:0] cd,
                         input logic kr, input logic [1:0] ka);
        bus.ctrl_req   = cr;
        bus.ctrl_we    = cw;
        bus.ctrl_addr  = ca;
        bus.ctrl_wdata = cd;
        bus.chk_req    = kr;
        bus.chk_addr   = ka;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    vec_t              tbl [12];
    logic [DATA_W-1:0] model_mem [ROWS];
    logic [DATA_W-1:0] exp_crd, exp_krd, pcd, pkd;
    logic              pc, pk, eg_c, eg_k;
    logic              c_req, c_we, k_req;
    logic [ADDR_W-1:0] c_addr, k_addr;
    logic [DATA_W-1:0] c_wd;
    int                burst;
    arb_state_t        exp_state;

    initial begin
        drive(0, 0, 0, 0, 0, 0);
        RST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst ctrl_gnt", 32'(bus.ctrl_gnt), 0);
        check("rst chk_gnt", 32'(bus.chk_gnt), 0);
        check("rst ctrl_rvalid", 32'(bus.ctrl_rvalid), 0);
        check("rst chk_rvalid", 32'(bus.chk_rvalid), 0);
        check("rst ram_wren", 32'(bus.ram_wren), 0);
        check("rst ram_addr", 32'(bus.ram_addr), 0);
        check("rst ram_wdata", 32'(bus.ram_wdata), 0);
        check("rst ctrl_rdata", 32'(bus.ctrl_rdata), 0);
        check("rst chk_rdata", 32'(bus.chk_rdata), 0);
        check("rst state", 32'(dbg_state), 32'(ST_IDLE));
        @(negedge CLK);
        RST = 1'b1;
        repeat (3) tick();

        // Directed table: row i inputs are sampled at the next edge, its outputs checked after it
        tbl[0]  = mk(1, 1, 1, 24'hABCDEF, 0, 0,  1, 0, 0, 0, 24'h0,      24'h0,      1, 1);
        tbl[1]  = mk(1, 0, 1, 24'h0,      0, 0,  1, 0, 0, 0, 24'h0,      24'h0,      0, 1);
        tbl[2]  = mk(0, 0, 0, 24'h0,      0, 0,  0, 0, 1, 0, 24'hABCDEF, 24'h0,      0, 0);
        tbl[3]  = mk(0, 0, 0, 24'h0,      1, 0,  0, 1, 0, 0, 24'hABCDEF, 24'h0,      0, 0);
        tbl[4]  = mk(0, 0, 0, 24'h0,      1, 1,  0, 1, 0, 1, 24'hABCDEF, 24'h111111, 0, 1);
        tbl[5]  = mk(0, 0, 0, 24'h0,      1, 2,  0, 1, 0, 1, 24'hABCDEF, 24'hABCDEF, 0, 2);
        tbl[6]  = mk(0, 0, 0, 24'h0,      1, 3,  0, 1, 0, 1, 24'hABCDEF, 24'h333333, 0, 3);
        tbl[7]  = mk(0, 0, 0, 24'h0,      0, 0,  0, 0, 0, 1, 24'hABCDEF, 24'h444444, 0, 0);
        tbl[8]  = mk(1, 1, 3, 24'h123456, 1, 3,  1, 0, 0, 0, 24'hABCDEF, 24'h444444, 1, 3);
        tbl[9]  = mk(0, 0, 0, 24'h0,      1, 3,  0, 1, 0, 0, 24'hABCDEF, 24'h444444, 0, 3);
        tbl[10] = mk(0, 0, 0, 24'h0,      0, 0,  0, 0, 0, 1, 24'hABCDEF, 24'h123456, 0, 0);
        tbl[11] = mk(0, 0, 0, 24'h0,      0, 0,  0, 0, 0, 0, 24'hABCDEF, 24'h123456, 0, 0);

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].cr, tbl[i].cw, tbl[i].ca, tbl[i].cd, tbl[i].kr, tbl[i].ka);
            tick();
            check($sformatf("vec%0d ctrl_gnt", i), 32'(bus.ctrl_gnt), 32'(tbl[i].e_cg));
            check($sformatf("vec%0d chk_gnt", i), 32'(bus.chk_gnt), 32'(tbl[i].e_kg));
            check($sformatf("vec%0d ctrl_rvalid", i), 32'(bus.ctrl_rvalid), 32'(tbl[i].e_crv));
            check($sformatf("vec%0d chk_rvalid", i), 32'(bus.chk_rvalid), 32'(tbl[i].e_krv));
            check($sformatf("vec%0d ctrl_rdata", i), 32'(bus.ctrl_rdata), 32'(tbl[i].e_crd));
            check($sformatf("vec%0d chk_rdata", i), 32'(bus.chk_rdata), 32'(tbl[i].e_krd));
            check($sformatf("vec%0d ram_wren", i), 32'(bus.ram_wren), 32'(tbl[i].e_wren));
            if (tbl[i].e_cg || tbl[i].e_kg)
                check($sformatf("vec%0d ram_addr", i), 32'(bus.ram_addr), 32'(tbl[i].e_addr));
        end

        // Both requesters held continuously
        drive(1, 0, 0, 0, 1, 1);
        for (int i = 0; i < 15; i++) begin
            tick();
`ifdef SUDOKU_ARB_FAIRNESS_EN
            check($sformatf("burst%0d chk_gnt", i), 32'(bus.chk_gnt), 32'((i % 5) == 4));
            check($sformatf("burst%0d ctrl_gnt", i), 32'(bus.ctrl_gnt), 32'((i % 5) != 4));
`else
            check($sformatf("burst%0d chk_gnt", i), 32'(bus.chk_gnt), 0);
            check($sformatf("burst%0d ctrl_gnt", i), 32'(bus.ctrl_gnt), 1);
`endif
        end
        drive(0, 0, 0, 0, 1, 1);
        tick();
        check("ctrl drop chk_gnt", 32'(bus.chk_gnt), 1);
        check("ctrl drop ctrl_gnt", 32'(bus.ctrl_gnt), 0);
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) tick();

        // Random traffic against the reference model
        model_mem[0] = 24'h111111;
        model_mem[1] = 24'hABCDEF;
        model_mem[2] = 24'h333333;
        model_mem[3] = 24'h123456;
        exp_crd = 24'h111111;
        exp_krd = 24'hABCDEF;
        pc = 0; pk = 0; pcd = '0; pkd = '0;
        burst = 0;
        c_req = 0; c_we = 0; c_addr = 0; c_wd = 0; k_req = 0; k_addr = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            drive(c_req, c_we, c_addr, c_wd, k_req, k_addr);
            tick();
`ifdef SUDOKU_ARB_FAIRNESS_EN
            eg_k = k_req && (!c_req || burst >= MAXB);
`else
            eg_k = k_req && !c_req;
`endif
            eg_c = c_req && !eg_k;
            if (pc) exp_crd = pcd;
            if (pk) exp_krd = pkd;
            exp_state = eg_c ? ST_CTRL : (eg_k ? ST_CHK : ST_IDLE);
            check("rnd ctrl_gnt", 32'(bus.ctrl_gnt), 32'(eg_c));
            check("rnd chk_gnt", 32'(bus.chk_gnt), 32'(eg_k));
            check("rnd state", 32'(dbg_state), 32'(exp_state));
            check("rnd ctrl_rvalid", 32'(bus.ctrl_rvalid), 32'(pc));
            check("rnd chk_rvalid", 32'(bus.chk_rvalid), 32'(pk));
            check("rnd ctrl_rdata", 32'(bus.ctrl_rdata), 32'(exp_crd));
            check("rnd chk_rdata", 32'(bus.chk_rdata), 32'(exp_krd));
            check("rnd ram_wren", 32'(bus.ram_wren), 32'(eg_c && c_we));
            if (eg_c) begin
                check("rnd ctrl ram_addr", 32'(bus.ram_addr), 32'(c_addr));
                if (c_we) check("rnd ram_wdata", 32'(bus.ram_wdata), 32'(c_wd));
            end
            if (eg_k) check("rnd chk ram_addr", 32'(bus.ram_addr), 32'(k_addr));

            pc = 0;
            pk = 0;
            if (eg_c) begin
                if (c_we) model_mem[c_addr] = c_wd;
                else begin
                    pc = 1;
                    pcd = model_mem[c_addr];
                end
            end
            if (eg_k) begin
                pk = 1;
                pkd = model_mem[k_addr];
            end
            if (!k_req || eg_k) burst = 0;
            else if (eg_c && burst < MAXB) burst++;

            if (!c_req || eg_c) begin
                c_req  = ($urandom_range(0, 99) < 60);
                c_we   = 1'($urandom_range(0, 1));
                c_addr = 2'($urandom_range(0, 3));
                c_wd   = 24'($urandom);
            end
            if (!k_req || eg_k) begin
                k_req  = ($urandom_range(0, 99) < 60);
                k_addr = 2'($urandom_range(0, 3));
            end
        end
        drive(0, 0, 0, 0, 0, 0);
        repeat (3) tick();

        // Reset while a controller read of row 2 is in flight
        drive(1, 0, 2, 0, 0, 0);
        tick();
        check("mid ctrl_gnt", 32'(bus.ctrl_gnt), 1);
        drive(0, 0, 0, 0, 0, 0);
        #2;
        RST = 1'b0;
        #1;
        check("mid rst ctrl_gnt", 32'(bus.ctrl_gnt), 0);
        check("mid rst ctrl_rvalid", 32'(bus.ctrl_rvalid), 0);
        check("mid rst ram_addr", 32'(bus.ram_addr), 0);
        check("mid rst ram_wren", 32'(bus.ram_wren), 0);
        check("mid rst ram_wdata", 32'(bus.ram_wdata), 0);
        check("mid rst ctrl_rdata", 32'(bus.ctrl_rdata), 0);
        check("mid rst chk_rdata", 32'(bus.chk_rdata), 0);
        check("mid rst state", 32'(dbg_state), 32'(ST_IDLE));
        @(posedge CLK);
        @(negedge CLK);
        drive(1, 0, 0, 0, 0, 0);
        RST = 1'b1;
        tick();
        check("post rst edge1 ctrl_gnt", 32'(bus.ctrl_gnt), 0);
        check("post rst edge1 ctrl_rvalid", 32'(bus.ctrl_rvalid), 0);
        tick();
        check("post rst edge2 ctrl_gnt", 32'(bus.ctrl_gnt), 1);
        check("post rst edge2 ctrl_rvalid", 32'(bus.ctrl_rvalid), 0);
        drive(0, 0, 0, 0, 0, 0);
        tick();
        check("post rst read rvalid", 32'(bus.ctrl_rvalid), 1);
        check("post rst read rdata", 32'(bus.ctrl_rdata), 32'(model_mem[0]));
        check("post rst chk_rvalid", 32'(bus.chk_rvalid), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
